// File: rtl/vga_square_painter_pkg.sv
// Shared definitions for the square painter: PS/2 scan codes, decoder states
// and the command set produced by the keyboard decoder.
package vga_square_painter_pkg;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_C     = 8'h21;
  localparam logic [7:0] KEY_R     = 8'h2D;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  typedef enum logic {
    ST_IDLE,
    ST_BREAK
  } decState_t;

  typedef enum logic [2:0] {
    CMD_UP,
    CMD_DOWN,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_COLOR,
    CMD_CENTER
  } cmd_t;

  function automatic logic isCmdKey(input logic [7:0] code);
    return (code == KEY_W) || (code == KEY_A) || (code == KEY_S) ||
           (code == KEY_D) || (code == KEY_C) || (code == KEY_R);
  endfunction

  function automatic cmd_t keyToCmd(input logic [7:0] code);
    case (code)
      KEY_W:   return CMD_UP;
      KEY_S:   return CMD_DOWN;
      KEY_A:   return CMD_LEFT;
      KEY_D:   return CMD_RIGHT;
      KEY_C:   return CMD_COLOR;
      default: return CMD_CENTER;
    endcase
  endfunction

endpackage

// File: rtl/vga_square_painter_ps2_key_decoder.sv
// Synchronizes the PS/2 code byte, detects each new code once, drops
// break sequences and holds the latest command until the frame applies it.
module ps2_key_decoder
  import vga_square_painter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] keyCode_i,
  input  logic       clear_i,
  output logic [2:0] cmd_o,
  output logic       valid_o
);

  logic [7:0] sync1_q, sync2_q, prev_q;
  decState_t  state_q;
  cmd_t       cmd_q;
  logic       valid_q;
  logic       newCode;

  // A code counts once: on the zero-to-nonzero transition of the synced byte.
  assign newCode = (sync2_q != 8'd0) && (prev_q == 8'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 8'd0;
      sync2_q <= 8'd0;
      prev_q  <= 8'd0;
      state_q <= ST_IDLE;
      cmd_q   <= CMD_CENTER;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= keyCode_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (clear_i)
        valid_q <= 1'b0;
      // A load in the same cycle as a clear wins, so it survives to next frame.
      if (newCode) begin
        case (state_q)
          ST_IDLE: begin
            if (sync2_q == KEY_BREAK) begin
              state_q <= ST_BREAK;
            end else if (isCmdKey(sync2_q)) begin
              cmd_q   <= keyToCmd(sync2_q);
              valid_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_o   = cmd_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/vga_square_painter.sv
// Pixel source feeding the VGA controller: a keyboard-driven square on a
// 256x256 image area, with moves applied once per frame on APPLY_LINE.
module vga_square_painter
  import vga_square_painter_pkg::*;
#(
  parameter int         H_ORIGIN   = 100,
  parameter int         V_ORIGIN   = 142,
  parameter int         SIDE       = 16,
  parameter int         STEP       = 4,
  parameter int         APPLY_LINE = 400,
  parameter logic [2:0] BG         = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iKeyCode,
  input  logic [9:0] iHcounter,
  input  logic [9:0] iVcounter,
  output logic [2:0] oVGA_RGB,
  output logic [7:0] oXPos,
  output logic [7:0] oYPos,
  output logic [2:0] oColor
);

  localparam logic [8:0] MAX_POS = 9'(256 - SIDE);
  localparam logic [7:0] CENTER  = 8'((256 - SIDE) / 2);

  logic [7:0] xPos_q, xPos_d, yPos_q, yPos_d;
  logic [2:0] color_q, color_d, rgb_q, rgb_d;
  logic [2:0] cmdRaw;
  logic       cmdValid, strobe;
  logic [9:0] xRel, yRel;

  ps2_key_decoder uDecoder (
    .clk_i    (Clock),
    .rst_ni   (Reset),
    .keyCode_i(iKeyCode),
    .clear_i  (strobe),
    .cmd_o    (cmdRaw),
    .valid_o  (cmdValid)
  );

  assign strobe = (iHcounter == 10'd0) && (iVcounter == 10'(APPLY_LINE));

  // Position math is 9 bits wide so underflow shows up in bit 8 before clamping.
  function automatic logic [7:0] stepBack(input logic [7:0] pos);
    logic [8:0] t;
    t = {1'b0, pos} - 9'(STEP);
    return t[8] ? 8'd0 : t[7:0];
  endfunction

  function automatic logic [7:0] stepFwd(input logic [7:0] pos);
    logic [8:0] t;
    t = {1'b0, pos} + 9'(STEP);
    return (t > MAX_POS) ? MAX_POS[7:0] : t[7:0];
  endfunction

  function automatic logic [2:0] nextColor(input logic [2:0] c);
    logic [2:0] n;
    n = c + 3'd1;
    if (n == BG)
      n = n + 3'd1;
    return n;
  endfunction

  always_comb begin
    xPos_d  = xPos_q;
    yPos_d  = yPos_q;
    color_d = color_q;
    if (strobe && cmdValid) begin
      case (cmd_t'(cmdRaw))
        CMD_UP:     yPos_d  = stepBack(yPos_q);
        CMD_DOWN:   yPos_d  = stepFwd(yPos_q);
        CMD_LEFT:   xPos_d  = stepBack(xPos_q);
        CMD_RIGHT:  xPos_d  = stepFwd(xPos_q);
        CMD_COLOR:  color_d = nextColor(color_q);
        CMD_CENTER: begin
          xPos_d = CENTER;
          yPos_d = CENTER;
        end
        default: ;
      endcase
    end
  end

  // Left of / above the origin wraps to a large unsigned value and falls outside.
  assign xRel = iHcounter - 10'(H_ORIGIN);
  assign yRel = iVcounter - 10'(V_ORIGIN);

  always_comb begin
    rgb_d = BG;
    if ((xRel < 10'd256) && (yRel < 10'd256) &&
        ((xRel - {2'b00, xPos_q}) < 10'(SIDE)) &&
        ((yRel - {2'b00, yPos_q}) < 10'(SIDE)))
      rgb_d = color_q;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      xPos_q  <= CENTER;
      yPos_q  <= CENTER;
      color_q <= 3'b100;
      rgb_q   <= BG;
    end else begin
      xPos_q  <= xPos_d;
      yPos_q  <= yPos_d;
      color_q <= color_d;
      rgb_q   <= rgb_d;
    end
  end

  assign oVGA_RGB = rgb_q;
  assign oXPos    = xPos_q;
  assign oYPos    = yPos_q;
  assign oColor   = color_q;

endmodule
